// File: rtl/l5q1e_spram.sv
// l5q1e_spram: single-port synchronous RAM with registered read, selectable collision mode and optional output register
module l5q1e_spram #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 3,
    parameter                        WRITE_MODE = "WRITE_FIRST",
    parameter bit                    OUT_REG    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic [0:0]            wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta
);
    localparam int  DEPTH      = 2 ** ADDR_WIDTH;
    localparam bit  read_first = (WRITE_MODE == "READ_FIRST");
    localparam bit  no_change  = (WRITE_MODE == "NO_CHANGE");

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] latch = RST_VAL;
    logic [DATA_WIDTH-1:0] coll;

    // value the read latch takes when a write hits the same edge
    always_comb coll = no_change ? latch : read_first ? mem[addra] : dina;

    always_ff @(posedge clka) begin
        if (wea[0]) mem[addra] <= dina;
        if (rsta) latch <= RST_VAL;
        else latch <= wea[0] ? coll : mem[addra];
    end

    if (OUT_REG) begin : g_reg
        logic [DATA_WIDTH-1:0] pipe = RST_VAL;
        always_ff @(posedge clka) pipe <= rsta ? RST_VAL : latch;
        assign douta = pipe;
    end else begin : g_noreg
        assign douta = latch;
    end
endmodule

// File: tb/tb_l5q1e_spram.sv
// tb_l5q1e_spram: checks all collision modes and the output-register variant against an array model
module tb_l5q1e_spram;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] we = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout [4];
    logic [7:0] m [8];
    logic [7:0] e [4];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    l5q1e_spram #(.WRITE_MODE("WRITE_FIRST"), .OUT_REG(1'b0)) u_wf (
        .clka(clk), .rsta(rst), .wea(we), .addra(addr), .dina(din), .douta(dout[0]));
    l5q1e_spram #(.WRITE_MODE("READ_FIRST"), .OUT_REG(1'b0)) u_rf (
        .clka(clk), .rsta(rst), .wea(we), .addra(addr), .dina(din), .douta(dout[1]));
    l5q1e_spram #(.WRITE_MODE("NO_CHANGE"), .OUT_REG(1'b0)) u_nc (
        .clka(clk), .rsta(rst), .wea(we), .addra(addr), .dina(din), .douta(dout[2]));
    l5q1e_spram #(.WRITE_MODE("WRITE_FIRST"), .OUT_REG(1'b1)) u_pipe (
        .clka(clk), .rsta(rst), .wea(we), .addra(addr), .dina(din), .douta(dout[3]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/wf"}, dout[0], e[0]);
        chk({tag, "/rf"}, dout[1], e[1]);
        chk({tag, "/nc"}, dout[2], e[2]);
        chk({tag, "/pipe"}, dout[3], e[3]);
    endtask

    // one clock edge of stimulus; the model follows the behavioural rules directly
    task automatic step(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d, input string tag);
        logic [7:0] old;
        @(negedge clk);
        rst = r; we = w; addr = a; din = d;
        @(posedge clk);
        old = m[a];
        e[3] = r ? 8'h00 : e[0];
        e[0] = r ? 8'h00 : (w ? d : old);
        e[1] = r ? 8'h00 : old;
        e[2] = r ? 8'h00 : (w ? e[2] : old);
        if (w) m[a] = d;
        #1;
        chk_all(tag);
    endtask

    initial begin
        foreach (m[i]) m[i] = 8'h00;
        foreach (e[i]) e[i] = 8'h00;
        #1;
        chk_all("powerup");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 3'(i), 8'hFF, "sweep");
            chk("sweep_zero", dout[0], 8'h00);
        end
        step(1'b0, 1'b1, 3'd3, 8'hA5, "wr3");
        chk("wr3_wf", dout[0], 8'hA5);
        step(1'b0, 1'b0, 3'd5, 8'h00, "rd5");
        chk("rd5_wf", dout[0], 8'h00);
        step(1'b0, 1'b0, 3'd3, 8'h00, "rd3");
        chk("rd3_wf", dout[0], 8'hA5);
        step(1'b0, 1'b1, 3'd2, 8'h11, "wr2a");
        step(1'b0, 1'b0, 3'd3, 8'h00, "prior");
        step(1'b0, 1'b1, 3'd2, 8'h22, "coll");
        chk("coll_wf", dout[0], 8'h22);
        chk("coll_rf", dout[1], 8'h11);
        chk("coll_nc", dout[2], 8'hA5);
        step(1'b0, 1'b0, 3'd2, 8'h00, "rd2");
        chk("rd2_rf", dout[1], 8'h22);
        chk("rd2_nc", dout[2], 8'h22);
        step(1'b0, 1'b0, 3'd3, 8'h00, "pre_rst");
        step(1'b1, 1'b1, 3'd6, 8'h3C, "rst_wr6");
        chk("rst_wf", dout[0], 8'h00);
        chk("rst_pipe", dout[3], 8'h00);
        step(1'b0, 1'b0, 3'd6, 8'h00, "rd6");
        chk("rd6_wf", dout[0], 8'h3C);
        step(1'b0, 1'b0, 3'd3, 8'h00, "rd3b");
        chk("rd3b_wf", dout[0], 8'hA5);
        step(1'b0, 1'b1, 3'd7, 8'h7E, "wr7");
        step(1'b0, 1'b0, 3'd7, 8'h00, "rd7");
        step(1'b0, 1'b0, 3'd0, 8'h00, "rd7_lat2");
        chk("pipe_lat2", dout[3], 8'h7E);
        step(1'b1, 1'b0, 3'd0, 8'h00, "pipe_rst");
        chk("pipe_rst", dout[3], 8'h00);
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 15) == 0), 1'($urandom), 3'($urandom), 8'($urandom), "rand");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/l5q1e_spram.md
Name: l5q1e_spram

Overview:
- Single-port synchronous block RAM: 8 words x 8 bits, one shared address for reads and writes.
- Drop-in equivalent of the Core Generator memory l5q1e (port A only), plus a synchronous output reset.
- Used as a small scratch/lookup store.
- Read data is registered. Write-first collision semantics.

Parameters:
- DATA_WIDTH, 8, width of dina/douta and of each memory word.
- ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH (8 words).
- WRITE_MODE, "WRITE_FIRST", collision behaviour on write; also supports "READ_FIRST" and "NO_CHANGE".
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output pipeline register (2-cycle latency).
- RST_VAL, 8'h00, value loaded into the output register(s) on reset.

Ports:
- clka  in  1  clock; all logic on the rising edge.
- rsta  in  1  synchronous, active-high reset of the output latch/register(s) only.
- wea  in  1 ([0:0])  write enable.
- addra  in  ADDR_WIDTH  word address.
- dina  in  DATA_WIDTH  write data.
- douta  out  DATA_WIDTH  read data.

Behaviour:
- Memory array: 2**ADDR_WIDTH words. All words are 0 at power-up/configuration. rsta never clears the array.
- Write: on a rising clka edge with wea=1, mem[addra] <= dina. A write takes effect even while rsta=1.
- Read, OUT_REG=0: on every rising edge, the output latch updates from mem[addra] sampled at that edge. douta is valid 1 cycle after the address.
- Collision (wea=1 at the same edge):
  - WRITE_FIRST: latch <= dina.
  - READ_FIRST: latch <= old mem[addra].
  - NO_CHANGE: latch holds its previous value.
- OUT_REG=1: a second register samples the latch each edge, so latency = 2 cycles.
- Reset: at a rising edge with rsta=1, the latch <= RST_VAL and (if OUT_REG=1) the output register <= RST_VAL. Reset has priority over the read/collision update.
- After reset deasserts, the next edge resumes normal reads. The first valid read data appears 1 (or 2) edges later.
- douta before the first clock edge: RST_VAL.
- Address wrap: addra is exactly ADDR_WIDTH bits, so there is no out-of-range condition.
- Unknown/X inputs need no special handling.
- No handshake. A read is performed on every cycle.
- Inputs are sampled only at the clka rising edge. Mid-cycle changes have no effect.

Test Plan:
- Power-up read: rsta=0, wea=0, sweep addra 0..7 -> douta=8'h00 for every address, one cycle after each address.
- Write then read (WRITE_FIRST, OUT_REG=0):
  - Write addra=3 dina=8'hA5 -> douta=8'hA5 at the same edge.
  - Then wea=0 addra=5 -> 8'h00.
  - Then addra=3 -> 8'hA5 one cycle later.
- Collision modes: mem[2]=8'h11, then write 8'h22 to addr 2:
  - WRITE_FIRST -> douta=8'h22.
  - READ_FIRST -> douta=8'h11.
  - NO_CHANGE -> douta keeps its prior value.
  - A subsequent read in every mode -> 8'h22.
- Reset mid-operation:
  - douta=8'hA5, assert rsta for one edge with wea=1 addra=6 dina=8'h3C -> douta=8'h00.
  - Then read addr 6 -> 8'h3C, and addr 3 -> still 8'hA5 (array not cleared).
- Latency with OUT_REG=1: write 8'h7E to addr 7, then read addr 7 -> douta=8'h7E two edges after the address. A reset clears both stages to 8'h00 on the next edge.
- Random stress: 10+ cycles of random wea/addra/dina checked against a scoreboard model of the 8-word array. Every douta must match the model for the configured mode and latency.
